// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: entry layout, CDB packet and pointer widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lsq_pkg;

    localparam int LSQ_TAG_W  = 4;
    localparam int LSQ_DATA_W = 32;
    localparam int LSQ_ADDR_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  load;
        logic [LSQ_TAG_W-1:0]  tag;
        logic [LSQ_ADDR_W-1:0] addr;
        logic                  addr_vld;
        logic [LSQ_DATA_W-1:0] data;
        logic                  data_vld;
        logic [LSQ_TAG_W-1:0]  data_tag;
    } lsq_entry_t;

    typedef struct packed {
        logic                  vld;
        logic [LSQ_TAG_W-1:0]  tag;
        logic [LSQ_DATA_W-1:0] result;
    } cdb_packet_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lsq_load_ret.sv
// One-entry load-result holding stage between dmem read data and the CDB arbiter.
// Latency: result visible the cycle after issue (mem_rdata passed through, then held).
// Backpressure: result held stable until ld_ready; can_accept low while an unaccepted result sits here.
module lsq_load_ret
#(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              can_accept,
    output logic              ld_valid,
    input  logic              ld_ready,
    output logic [TAG_W-1:0]  ld_tag,
    output logic [DATA_W-1:0] ld_data
);

    logic              vld_q;
    logic              fresh_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;

    assign can_accept = !vld_q || ld_ready;
    assign ld_valid   = vld_q;
    assign ld_tag     = tag_q;
    // mem_rdata is only valid the cycle after the read strobe, so it is shown
    // directly then and held from data_q afterwards.
    assign ld_data    = fresh_q ? mem_rdata : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= 1'b0;
            fresh_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (flush) begin
            vld_q   <= 1'b0;
            fresh_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (fresh_q) begin
                data_q <= mem_rdata;
            end
            if (issue) begin
                vld_q   <= 1'b1;
                fresh_q <= 1'b1;
                tag_q   <= issue_tag;
            end else begin
                fresh_q <= 1'b0;
                if (ld_ready) begin
                    vld_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: buffers memory ops, snoops the CDB for addresses and store data.
// Latency: ready load head -> mem_rd_en same cycle, ld_valid next cycle; committed ready store written same cycle.
// Backpressure: enq_ready = !full; loads stall while a result is held unaccepted; stores wait for commit.
module load_store_queue
    import lsq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = LSQ_TAG_W,
    parameter int DATA_W = LSQ_DATA_W,
    parameter int ADDR_W = LSQ_ADDR_W
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic                   enq_load,
    input  logic [TAG_W-1:0]       enq_tag,
    input  logic                   enq_data_rdy,
    input  logic [TAG_W-1:0]       enq_data_tag,
    input  logic [DATA_W-1:0]      enq_data,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic [DATA_W-1:0]      cdb_result,
    input  logic                   commit_valid,
    input  logic [TAG_W-1:0]       commit_tag,
    output logic                   commit_ack,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   ld_valid,
    input  logic                   ld_ready,
    output logic [TAG_W-1:0]       ld_tag,
    output logic [DATA_W-1:0]      ld_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    lsq_entry_t       q [DEPTH];
    lsq_entry_t       head;
    lsq_entry_t       new_ent;
    cdb_packet_t      cdb;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             enq_fire;
    logic             head_rdy;
    logic             ld_issue;
    logic             st_write;
    logic             deq;
    logic             ret_can_accept;

    assign cdb = '{vld: cdb_valid, tag: cdb_tag, result: cdb_result};

    assign head      = q[rptr];
    assign count     = cnt;
    assign full      = (cnt == CNT_W'(DEPTH));
    assign empty     = (cnt == '0);
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && enq_ready && !flush;

    assign head_rdy = head.valid && head.addr_vld && (head.load || head.data_vld);
    assign ld_issue = !flush && head_rdy && head.load && ret_can_accept;
    assign st_write = !flush && head_rdy && !head.load && commit_valid && (commit_tag == head.tag);
    assign deq      = ld_issue || st_write;

    assign mem_rd_en  = ld_issue;
    assign mem_wr_en  = st_write;
    assign commit_ack = st_write;
    assign mem_addr   = head.addr;
    assign mem_wdata  = head.data;

    // New entry, with a same-cycle CDB broadcast folded in so it is not missed.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.load     = enq_load;
        new_ent.tag      = enq_tag;
        new_ent.data_tag = enq_data_tag;
        if (cdb.vld && (cdb.tag == enq_tag)) begin
            new_ent.addr     = cdb.result[ADDR_W-1:0];
            new_ent.addr_vld = 1'b1;
        end
        if (enq_data_rdy) begin
            new_ent.data     = enq_data;
            new_ent.data_vld = 1'b1;
        end else if (!enq_load && cdb.vld && (cdb.tag == enq_data_tag)) begin
            new_ent.data     = cdb.result;
            new_ent.data_vld = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid && cdb.vld) begin
                    if ((cdb.tag == q[i].tag) && !q[i].addr_vld) begin
                        q[i].addr     <= cdb.result[ADDR_W-1:0];
                        q[i].addr_vld <= 1'b1;
                    end
                    if (!q[i].load && !q[i].data_vld && (cdb.tag == q[i].data_tag)) begin
                        q[i].data     <= cdb.result;
                        q[i].data_vld <= 1'b1;
                    end
                end
            end
            if (deq) begin
                q[rptr].valid <= 1'b0;
                rptr          <= rptr + PTR_W'(1);
            end
            // A full queue refuses enqueue, so wptr never lands on the slot being dequeued.
            if (enq_fire) begin
                q[wptr] <= new_ent;
                wptr    <= wptr + PTR_W'(1);
            end
            case ({enq_fire, deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    lsq_load_ret #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_load_ret (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .issue      (ld_issue),
        .issue_tag  (head.tag),
        .mem_rdata  (mem_rdata),
        .can_accept (ret_can_accept),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_tag     (ld_tag),
        .ld_data    (ld_data)
    );

endmodule
